deferred_check_array: RTL and testbench
=======================================

// Module: deferred_check_array
// PURPOSE
//  Clocked, multi-channel checker array with deferred-assertion semantics.
//  Each check samples a condition, holds the failure as pending for one cycle,
//  then reports it only if the channel was not disabled or cleared meanwhile.
//  Sits beside datapath/FSM blocks as a synthesizable monitor of data-path invariants.
//  Provides per-channel failure counts, first-failure capture and a sticky fatal flag.
// PARAMETERS
//  NUM_CH   4  number of independent check channels (>=1)
//  DATA_W   8  operand width per channel
//  CNT_W    8  per-channel failure counter width; saturates at 2**CNT_W-1
//  IDX_W    localparam = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//  clk            in   1            single clock, all state on posedge
//  rst            in   1            synchronous, active-high reset
//  chk_valid      in   NUM_CH       evaluate channel check this cycle
//  chk_mode       in   2*NUM_CH     per ch: 00 EQ a==b, 01 AND |a&&|b, 10 OR |a|||b, 11 NZ |a
//  chk_a          in   NUM_CH*DATA_W  operand a, ch i at [i*DATA_W +: DATA_W]
//  chk_b          in   NUM_CH*DATA_W  operand b, same packing
//  ch_disable     in   NUM_CH       flush pending fail, suppress sample this cycle
//  ch_clear       in   NUM_CH       as ch_disable, plus zero the channel counter
//  fatal_en       in   NUM_CH       a matured fail on this channel raises fatal
//  fail_pulse     out  NUM_CH       1-cycle pulse per matured failure
//  fail_cnt       out  NUM_CH*CNT_W saturating matured-failure count per channel
//  any_fail       out  1            sticky: any failure has matured since reset
//  first_fail_vld out  1            first_fail_ch holds a valid value
//  first_fail_ch  out  IDX_W        channel of first matured failure
//  fatal          out  1            sticky fatal flag; blocks all new activity
// BEHAVIOUR
//  Reset (rst=1 at posedge): pend, fail_pulse, fail_cnt, any_fail, first_fail_vld,
//   first_fail_ch and fatal all go to 0. rst has priority over every other input.
//  Check result: fails_i = chk_valid[i] & ~cond_i(chk_mode[i], a, b).
//  blk_i = ch_disable[i] | ch_clear[i] | fatal.
//  Per edge: pend_i <= fails_i & ~blk_i; mature_i = pend_i & ~blk_i.
//   fail_pulse_i <= mature_i.
//  Latency: an input failing in cycle N gives fail_pulse in cycle N+2.
//   A disable or clear in cycle N or N+1 cancels that failure; no pulse, no count.
//  Counter update: on mature_i, fail_cnt_i increments, holding at all-ones on overflow.
//   On ch_clear[i], fail_cnt_i <= 0; clear wins over mature, since mature is blocked.
//  any_fail <= any_fail | (|mature).
//  First failure: captured when first_fail_vld=0 and |mature.
//   first_fail_ch takes the lowest-index maturing channel; vld then holds until rst.
//  Fatal: set on the edge where mature_i & fatal_en[i] for any i.
//   That failure is still pulsed and counted.
//   After that, blk=1 for all channels: no new pend or mature.
//   Counters freeze; ch_clear still zeroes them. Only rst clears fatal.
//  Back-to-back: a failing check every cycle gives a pulse every cycle; pend is
//   one stage deep, one stage per channel, and channels are fully independent.
//  No combinational path from any input to any output.
// CONFIGURATION
//  DCHK_TSTAMP_EN defined: adds a free-running 32-bit cycle counter, 0 at reset,
//   wrapping at 2**32-1.
//   Adds output first_fail_ts[31:0], the counter value on the edge of first
//   capture; 0 until then.
//  Not defined: no counter and no first_fail_ts port; all other behaviour is identical.
// TESTING
//  T1 reset: rst=1 for 2 cycles with random inputs -> all outputs 0.
//  T2 latency: ch0 EQ, a=5, b=6, valid in cycle 10 only
//   -> fail_pulse[0]=1 in cycle 12 only; fail_cnt0=1; first_fail_ch=0; any_fail=1.
//  T3 cancel: ch1 OR, a=0, b=0, valid cycle 20; ch_disable[1]=1 in cycle 21
//   -> no pulse, cnt1 stays 0.
//   Repeat with ch_clear in cycle 20 -> same result.
//  T4 saturate/clear: CNT_W=4, ch2 NZ a=0, valid for 20 cycles -> cnt2 stops at 15;
//   ch_clear[2] for 1 cycle -> cnt2=0, then counting resumes.
//  T5 simultaneous/fatal: ch3 and ch1 both fail in cycle 30, fatal_en=4'b1000
//   -> first_fail_ch=1; fatal=1 in cycle 32; cnt1 and cnt3 each increment once.
//   Further failures give no pulses until rst.
//  T6 pass modes: AND a=3, b=1 and EQ a=b=9 with valid every cycle for 50 cycles
//   -> no pulses; with DCHK_TSTAMP_EN, first_fail_ts matches the capture cycle.

Source files
------------

// File: rtl/deferred_check_array_if.sv
// Check-array bus: check requests and cancel controls in, failure reporting out.
// DCHK_TSTAMP_EN adds the first_fail_ts signal.
interface deferred_check_array_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        chk_valid;
  logic [2*NUM_CH-1:0]      chk_mode;
  logic [NUM_CH*DATA_W-1:0] chk_a;
  logic [NUM_CH*DATA_W-1:0] chk_b;
  logic [NUM_CH-1:0]        ch_disable;
  logic [NUM_CH-1:0]        ch_clear;
  logic [NUM_CH-1:0]        fatal_en;
  logic [NUM_CH-1:0]        fail_pulse;
  logic [NUM_CH*CNT_W-1:0]  fail_cnt;
  logic                     any_fail;
  logic                     first_fail_vld;
  logic [IDX_W-1:0]         first_fail_ch;
  logic                     fatal;
`ifdef DCHK_TSTAMP_EN
  logic [31:0]              first_fail_ts;
`endif

  modport master (
    output chk_valid, chk_mode, chk_a, chk_b, ch_disable, ch_clear, fatal_en,
    input  fail_pulse, fail_cnt, any_fail, first_fail_vld, first_fail_ch, fatal
`ifdef DCHK_TSTAMP_EN
    , input first_fail_ts
`endif
  );

  modport slave (
    input  chk_valid, chk_mode, chk_a, chk_b, ch_disable, ch_clear, fatal_en,
    output fail_pulse, fail_cnt, any_fail, first_fail_vld, first_fail_ch, fatal
`ifdef DCHK_TSTAMP_EN
    , output first_fail_ts
`endif
  );
endinterface

// File: rtl/deferred_check_array.sv
// Multi-channel deferred checker: failures wait one cycle in a pending stage and
// are reported only if not cancelled. DCHK_TSTAMP_EN adds a first-failure timestamp.
module deferred_check_array #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  deferred_check_array_if.slave  bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       cond;
  logic [NUM_CH-1:0]       fails;
  logic [NUM_CH-1:0]       blk;
  logic [NUM_CH-1:0]       mature;
  logic [NUM_CH-1:0]       pend_q, pend_d;
  logic [NUM_CH-1:0]       pulse_q;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic                    any_fail_q, any_fail_d;
  logic                    first_vld_q, first_vld_d;
  logic [IDX_W-1:0]        first_ch_q, first_ch_d;
  logic [IDX_W-1:0]        first_idx;
  logic                    fatal_q, fatal_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [1:0]        mode;
      logic [CNT_W-1:0]  cnt_cur;

      assign a       = bus.chk_a[gi*DATA_W +: DATA_W];
      assign b       = bus.chk_b[gi*DATA_W +: DATA_W];
      assign mode    = bus.chk_mode[2*gi +: 2];
      assign cnt_cur = cnt_q[gi*CNT_W +: CNT_W];

      assign cond[gi] = (mode == 2'b00) ? (a == b) :
                        (mode == 2'b01) ? ((|a) && (|b)) :
                        (mode == 2'b10) ? ((|a) || (|b)) :
                                          (|a);

      // A fatal condition blocks every channel, freezing pend and counters.
      assign blk[gi]    = bus.ch_disable[gi] | bus.ch_clear[gi] | fatal_q;
      assign fails[gi]  = bus.chk_valid[gi] & ~cond[gi];
      assign pend_d[gi] = fails[gi] & ~blk[gi];
      assign mature[gi] = pend_q[gi] & ~blk[gi];

      assign cnt_d[gi*CNT_W +: CNT_W] =
          bus.ch_clear[gi]                     ? '0 :
          (mature[gi] && (cnt_cur != '1))      ? cnt_cur + {{(CNT_W-1){1'b0}}, 1'b1} :
                                                 cnt_cur;
    end
  endgenerate

  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mature[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    any_fail_d  = any_fail_q | (|mature);
    fatal_d     = fatal_q | (|(mature & bus.fatal_en));
    first_vld_d = first_vld_q;
    first_ch_d  = first_ch_q;
    if (!first_vld_q && (|mature)) begin
      first_vld_d = 1'b1;
      first_ch_d  = first_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pulse_q     <= '0;
      cnt_q       <= '0;
      any_fail_q  <= 1'b0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      fatal_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pulse_q     <= mature;
      cnt_q       <= cnt_d;
      any_fail_q  <= any_fail_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      fatal_q     <= fatal_d;
    end
  end

`ifdef DCHK_TSTAMP_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ts_q, ts_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ts_d  = ts_q;
    if (!first_vld_q && (|mature)) ts_d = cyc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign bus.first_fail_ts = ts_q;
`endif

  assign bus.fail_pulse     = pulse_q;
  assign bus.fail_cnt       = cnt_q;
  assign bus.any_fail       = any_fail_q;
  assign bus.first_fail_vld = first_vld_q;
  assign bus.first_fail_ch  = first_ch_q;
  assign bus.fatal          = fatal_q;
endmodule

// File: tb/tb_deferred_check_array.sv
// Directed bench for deferred_check_array: latency, cancel, saturation, fatal, pass modes.
module tb_deferred_check_array;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic [31:0] exp_ts;
  logic [NUM_CH-1:0] acc;

  always #5 clk = ~clk;

  deferred_check_array_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dif ();

  deferred_check_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    $display("[%0t] check %s obs=%0h exp=%0h", $time, tag, obs, expv);
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; cyc mirrors the free-running cycle counter (reset to 0 by rst).
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    if (r) cyc = 0;
    else   cyc = cyc + 1;
    #1;
  endtask

  task automatic idle();
    dif.chk_valid  = '0;
    dif.chk_mode   = '0;
    dif.chk_a      = '0;
    dif.chk_b      = '0;
    dif.ch_disable = '0;
    dif.ch_clear   = '0;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    dif.chk_valid[ch]        = 1'b1;
    dif.chk_mode[2*ch +: 2]  = m;
    dif.chk_a[ch*DATA_W +: DATA_W] = a;
    dif.chk_b[ch*DATA_W +: DATA_W] = b;
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(dif.fail_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  initial begin
    // T1 reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dif.chk_valid  = 4'($urandom);
      dif.chk_mode   = 8'($urandom);
      dif.chk_a      = 32'($urandom);
      dif.chk_b      = 32'($urandom);
      dif.ch_disable = 4'($urandom);
      dif.ch_clear   = 4'($urandom);
      dif.fatal_en   = 4'($urandom);
      tick();
    end
    check("rst_pulse", 32'(dif.fail_pulse), 32'h0);
    check("rst_cnt", dif.fail_cnt, 32'h0);
    check("rst_any", 32'(dif.any_fail), 32'h0);
    check("rst_vld", 32'(dif.first_fail_vld), 32'h0);
    check("rst_ch", 32'(dif.first_fail_ch), 32'h0);
    check("rst_fatal", 32'(dif.fatal), 32'h0);
    idle();
    dif.fatal_en = '0;
    rst = 1'b0;
    tick();

    // T2 latency: ch0 EQ 5 vs 6 for one cycle
    set_ch(0, 2'b00, 8'd5, 8'd6);
    tick();
    idle();
    check("t2_n1_pulse", 32'(dif.fail_pulse), 32'h0);
    tick();
    check("t2_n2_pulse", 32'(dif.fail_pulse), 32'h1);
    check("t2_cnt0", cnt(0), 32'd1);
    check("t2_any", 32'(dif.any_fail), 32'h1);
    check("t2_vld", 32'(dif.first_fail_vld), 32'h1);
    check("t2_ch", 32'(dif.first_fail_ch), 32'h0);
    tick();
    check("t2_n3_pulse", 32'(dif.fail_pulse), 32'h0);

    // T3 cancel: disable one cycle later, clear same cycle, then uncancelled control
    set_ch(1, 2'b10, 8'd0, 8'd0);
    tick();
    idle();
    dif.ch_disable = 4'b0010;
    tick();
    idle();
    check("t3a_pulse1", 32'(dif.fail_pulse), 32'h0);
    tick();
    check("t3a_pulse2", 32'(dif.fail_pulse), 32'h0);
    check("t3a_cnt1", cnt(1), 32'd0);

    set_ch(1, 2'b10, 8'd0, 8'd0);
    dif.ch_clear = 4'b0010;
    tick();
    idle();
    tick();
    check("t3b_pulse1", 32'(dif.fail_pulse), 32'h0);
    tick();
    check("t3b_pulse2", 32'(dif.fail_pulse), 32'h0);
    check("t3b_cnt1", cnt(1), 32'd0);

    set_ch(1, 2'b10, 8'd0, 8'd0);
    tick();
    idle();
    tick();
    check("t3c_pulse", 32'(dif.fail_pulse), 32'h2);
    check("t3c_cnt1", cnt(1), 32'd1);
    check("t3c_ch_held", 32'(dif.first_fail_ch), 32'h0);

    // T4 saturate then clear: ch2 NZ a=0 for 20 cycles
    for (int k = 0; k < 20; k++) begin
      set_ch(2, 2'b11, 8'd0, 8'd0);
      tick();
      if (k == 5)  check("t4_cnt_k5", cnt(2), 32'd5);
      if (k == 10) check("t4_b2b_pulse", 32'(dif.fail_pulse), 32'h4);
    end
    idle();
    tick();
    tick();
    check("t4_sat", cnt(2), 32'd15);
    dif.ch_clear = 4'b0100;
    tick();
    idle();
    check("t4_clr", cnt(2), 32'd0);
    set_ch(2, 2'b11, 8'd0, 8'd0);
    tick();
    idle();
    tick();
    check("t4_resume", cnt(2), 32'd1);

    // T5 simultaneous failures with fatal on ch3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_vld", 32'(dif.first_fail_vld), 32'h0);
    dif.fatal_en = 4'b1000;
    set_ch(1, 2'b00, 8'd1, 8'd2);
    set_ch(3, 2'b01, 8'd0, 8'd7);
    tick();
    idle();
    check("t5_fatal_n1", 32'(dif.fatal), 32'h0);
    exp_ts = 32'(cyc);
    tick();
    check("t5_fatal_n2", 32'(dif.fatal), 32'h1);
    check("t5_pulse", 32'(dif.fail_pulse), 32'ha);
    check("t5_cnt1", cnt(1), 32'd1);
    check("t5_cnt3", cnt(3), 32'd1);
    check("t5_first_ch", 32'(dif.first_fail_ch), 32'h1);
`ifdef DCHK_TSTAMP_EN
    check("t5_ts", dif.first_fail_ts, exp_ts);
`endif
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_ch(0, 2'b00, 8'd1, 8'd0);
      else idle();
      tick();
      acc = acc | dif.fail_pulse;
    end
    check("t5_blocked_pulse", 32'(acc), 32'h0);
    check("t5_blocked_cnt0", cnt(0), 32'd0);
    dif.ch_clear = 4'b0010;
    tick();
    idle();
    check("t5_clr_cnt1", cnt(1), 32'd0);
    check("t5_cnt3_frozen", cnt(3), 32'd1);
    check("t5_fatal_sticky", 32'(dif.fatal), 32'h1);

    // T6 pass modes for 50 cycles, then one timestamped failure
    dif.fatal_en = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc = '0;
    for (int k = 0; k < 50; k++) begin
      set_ch(0, 2'b01, 8'd3, 8'd1);
      set_ch(1, 2'b00, 8'd9, 8'd9);
      tick();
      acc = acc | dif.fail_pulse;
    end
    idle();
    tick();
    tick();
    acc = acc | dif.fail_pulse;
    check("t6_pulses", 32'(acc), 32'h0);
    check("t6_any", 32'(dif.any_fail), 32'h0);
    check("t6_cnt", dif.fail_cnt, 32'h0);
`ifdef DCHK_TSTAMP_EN
    check("t6_ts_idle", dif.first_fail_ts, 32'h0);
`endif
    set_ch(2, 2'b11, 8'd0, 8'd0);
    tick();
    idle();
    exp_ts = 32'(cyc);
    tick();
    check("t6_first_ch", 32'(dif.first_fail_ch), 32'h2);
    check("t6_fatal_off", 32'(dif.fatal), 32'h0);
`ifdef DCHK_TSTAMP_EN
    check("t6_ts", dif.first_fail_ts, exp_ts);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
